// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target receiver and the existing i2c_master.
// Holds bus constants, the target FSM state type and small helpers.
package i2c_pkg;

    localparam int   I2C_ADDR_W   = 7;
    localparam int   I2C_BYTE_W   = 8;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_state_e;

    function automatic logic i2c_maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda, detects scl edges and START/STOP conditions.
// Define I2C_TGT_GLITCH_FILT_EN to add a 3-sample majority filter (+2 clk latency).
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end

    // Idle bus level is high, so reset to 1 to avoid a false edge on exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

`ifdef I2C_TGT_GLITCH_FILT_EN
    logic [2:0] scl_hist_q, scl_hist_d;
    logic [2:0] sda_hist_q, sda_hist_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[1:0], scl_sync_q[SYNC_STAGES-1]};
        sda_hist_d = {sda_hist_q[1:0], sda_sync_q[SYNC_STAGES-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    // Majority over three registered samples: a level change needs two agreeing samples.
    assign scl_s = i2c_maj3(scl_hist_q);
    assign sda_s = i2c_maj3(sda_hist_q);
`else
    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // scl must be high in both samples so a same-cycle scl edge never reads as START/STOP.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: matches TGT_ADDR, ACKs bytes, hands data to local logic.
// Optional I2C_TGT_GLITCH_FILT_EN enables the input glitch filter in i2c_bus_sync.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TGT_ADDR    = 7'h42,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    input  logic                  rx_ready,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_first,
    output logic                  busy,
    output logic                  nack_sent
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_state_e            state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_first_q, rx_first_d;
    logic                  busy_q, busy_d;
    logic                  nack_q, nack_d;
    logic                  first_q, first_d;
    logic                  deliver_q, deliver_d;
    logic                  ack_bit;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        busy_d     = busy_q;
        nack_d     = nack_q;
        first_d    = first_q;
        deliver_d  = 1'b0;
        ack_bit    = I2C_NACK;

        // Byte hand-off trails the ACK decision by one cycle.
        if (deliver_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
            rx_first_d = first_q;
            first_d    = 1'b0;
        end

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
            nack_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[I2C_BYTE_W-1:1] == TGT_ADDR && shift_q[0] == I2C_RW_WRITE)
                            ack_bit = I2C_ACK;
                        sda_oe_d = (ack_bit == I2C_ACK);
                        if (ack_bit == I2C_ACK) begin
                            state_d = ADDR_ACK;
                            first_d = 1'b1;
                        end else begin
                            state_d = IGNORE;
                            // A read to our address is refused; other addresses are just not ours.
                            if (shift_q[I2C_BYTE_W-1:1] == TGT_ADDR)
                                nack_d = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        ack_bit  = rx_ready ? I2C_ACK : I2C_NACK;
                        sda_oe_d = (ack_bit == I2C_ACK);
                        if (ack_bit == I2C_ACK) begin
                            state_d   = DATA_ACK;
                            deliver_d = 1'b1;
                        end else begin
                            state_d = IGNORE;
                            nack_d  = 1'b1;
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // Hold sda low through the whole ACK clock, release at its falling edge.
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
            first_q    <= 1'b0;
            deliver_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            busy_q     <= busy_d;
            nack_q     <= nack_d;
            first_q    <= first_d;
            deliver_q  <= deliver_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign busy      = busy_q;
    assign nack_sent = nack_q;

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target; the downstream consumer of the existing i2c_master on the shared open-drain scl/sda bus.
- Oversamples scl/sda on the system clock, detects START and STOP, and matches a 7-bit address.
- ACKs the address and data bytes by pulling sda low through an output-enable.
- Delivers each received data byte to local logic with a one-cycle valid pulse and a ready-based ACK/NACK backpressure.

Parameters:
- TGT_ADDR, 7'h42, own 7-bit bus address
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (≥2)

Ports:
- clk  in  1  system clock; must be ≥8× SCL frequency
- rst  in  1  reset, asynchronous, active-high
- scl_i  in  1  bus SCL level (asynchronous)
- sda_i  in  1  bus SDA level (asynchronous)
- sda_oe  out  1  1 = drive sda low (open-drain); 0 = release
- rx_ready  in  1  local side can accept a byte; sampled at each data-byte ACK decision
- rx_data  out  8  last received data byte, MSB first on bus
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_first  out  1  qualifies rx_valid: first data byte after the address
- busy  out  1  1 from START until STOP
- nack_sent  out  1  sticky; set when any NACK is issued, cleared on next START

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, busy=0, nack_sent=0, state=IDLE, synchronisers=1.
- Bus sampling:
  - scl_s/sda_s are the synchronised levels; keep previous-cycle copies.
  - scl_rise/scl_fall are edges of scl_s.
  - START: sda_s 1→0 while scl_s=1. STOP: sda_s 0→1 while scl_s=1.
- Data bits are sampled on scl_rise and shifted MSB first into an 8-bit register; a 4-bit bit counter runs 0..8.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
  - ADDR_ACK: on the scl_fall after bit 8:
    - addr==TGT_ADDR and R/W=0: sda_oe=1, then DATA.
    - Otherwise: sda_oe stays 0; set nack_sent only on address match with R/W=1; go IGNORE.
  - DATA: shift 8 bits; then enter DATA_ACK on the scl_fall after bit 8:
    - rx_ready=1: sda_oe=1; next cycle rx_valid=1, rx_data=byte, rx_first=1 if first data byte.
    - rx_ready=0: sda_oe=0, nack_sent=1, no rx_valid, go IGNORE.
  - ACK release: sda_oe drops on the next scl_fall (end of the ACK clock). State returns to DATA with the bit counter cleared.
  - IGNORE: sda_oe=0; wait for START or STOP.
- START/STOP priority:
  - START in any state: repeated-start → ADDR, bit counter=0, sda_oe=0, busy=1, nack_sent=0.
  - STOP in any state: IDLE, busy=0, sda_oe=0. A partial byte is discarded with no rx_valid.
  - START/STOP take priority over a simultaneous scl edge (START/STOP by definition occur with scl_s=1, so a same-cycle scl_rise is ignored).
- busy: set the cycle after START is detected, cleared the cycle after STOP is detected.
- Latency: rx_valid is asserted SYNC_STAGES+2 clk after the bus scl falling edge that ends bit 8.
- Reset mid-transfer: immediate IDLE, bus released. The block remains in IDLE until a fresh START, even if SCL keeps toggling.
- The target never stretches SCL.

Optional Feature:
- I2C_TGT_GLITCH_FILT_EN
- Defined: a 3-sample majority filter follows each synchroniser. Pulses ≤1 clk are suppressed, and every detection/latency figure above grows by 2 clk.
- Undefined: raw synchroniser output is used; no added latency.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE)
  - I2C_ADDR_W=7, I2C_BYTE_W=8
  - I2C_ACK=1'b0, I2C_NACK=1'b1
  - I2C_RW_WRITE=1'b0
  - shared with i2c_master.
- Sub-module i2c_bus_sync: synchronisers, optional filter, scl edge detection, START/STOP detection. Reusable by the master for arbitration later.

Test Plan:
- i2c_master writes addr 7'h42, data 8'hA5, rx_ready=1 → both bytes ACKed; rx_valid pulse once with rx_data=8'hA5, rx_first=1; master ack_error=0; busy falls after STOP.
- Address 7'h43 → no ACK on the address; master ack_error=1; no rx_valid; nack_sent=0.
- Address 7'h42 with R/W=1 → address NACKed; nack_sent=1; state IGNORE until STOP.
- Bytes 8'h11, 8'h22 with rx_ready dropped before the second ACK → first byte ACKed with rx_valid (rx_first=1); second byte NACKed; nack_sent=1; rx_valid not pulsed for 8'h22.
- Repeated START after 4 data bits, then 7'h42 + 8'h3C → partial byte discarded; one rx_valid with 8'h3C, rx_first=1.
- Assert rst during the ACK slot of byte 1 → sda_oe=0 within the same cycle (async); busy=0; a fresh transaction afterwards completes normally.
